// File: rtl/search_update_scheduler.sv
// Arbitrates the search_stage slot between packet searches and rule-table writes,
// with starvation/burst limits and a pipeline drain for atomic updates. Optional stats: SEARCH_SCHED_STATS_EN.
module search_update_scheduler #(
    parameter int unsigned PIPE_DEPTH   = 8,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned BURST_MAX    = 4,
    parameter int unsigned DATA_W       = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pkt_valid_i,
    output logic                pkt_ready_o,
    input  logic [103:0]        pkt_tuple_i,
    input  logic                upd_valid_i,
    output logic                upd_ready_o,
    input  logic [2:0]          upd_group_i,
    input  logic                upd_atomic_i,
    input  logic [10:0]         upd_index_i,
    input  logic [DATA_W-1:0]   upd_data_i,
    output logic                srch_valid_o,
    output logic [103:0]        srch_tuple_o,
    output logic [5:0]          tbl_we_o,
    output logic [10:0]         tbl_waddr_o,
    output logic [DATA_W-1:0]   tbl_wdata_o,
    output logic                upd_err_o,
    output logic                drain_busy_o
`ifdef SEARCH_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_pkt_cnt_o,
    output logic [31:0]         stat_upd_cnt_o,
    output logic [31:0]         stat_drain_cyc_o
`endif
);

    localparam int unsigned TUPLE_W = 104;
    localparam int unsigned IDX_W   = 11;
    localparam int unsigned WE_W    = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BURST_W = 4;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_DRAIN  = 2'd1,
        S_WRITE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic                 srch_valid_q, srch_valid_d;
    logic [TUPLE_W-1:0]   srch_tuple_q, srch_tuple_d;
    logic [WE_W-1:0]      tbl_we_q, tbl_we_d;
    logic [IDX_W-1:0]     tbl_waddr_q, tbl_waddr_d;
    logic [DATA_W-1:0]    tbl_wdata_q, tbl_wdata_d;
    logic                 upd_err_q, upd_err_d;
    logic                 drain_busy_q, drain_busy_d;

    logic starve, burst_full, take_upd, pkt_hs, upd_hs, grp_legal;

    // Starvation overrides the burst limit; otherwise a waiting packet wins.
    assign starve     = wait_cnt_q >= CNT_W'(STARVE_LIMIT);
    assign burst_full = pkt_valid_i && (burst_cnt_q == BURST_W'(BURST_MAX));
    assign take_upd   = upd_valid_i && (!pkt_valid_i || starve) && (!burst_full || starve);
    assign grp_legal  = upd_group_i <= 3'd5;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        burst_cnt_d = burst_cnt_q;
        pkt_ready_o = 1'b0;
        upd_ready_o = 1'b0;
        case (state_q)
            S_SEARCH: begin
                if (take_upd) begin
                    if (!upd_atomic_i) begin
                        upd_ready_o = 1'b1;
                        if (pkt_valid_i && burst_cnt_q != '1) begin
                            burst_cnt_d = burst_cnt_q + BURST_W'(1);
                        end
                    end else begin
                        drain_cnt_d = CNT_W'(PIPE_DEPTH);
                        state_d     = S_DRAIN;
                    end
                end else begin
                    pkt_ready_o = 1'b1;
                    if (pkt_valid_i) begin
                        burst_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q - CNT_W'(1);
                if (!upd_valid_i) begin
                    state_d = S_SEARCH;
                end else if (drain_cnt_q == CNT_W'(1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                upd_ready_o = 1'b1;
                state_d     = S_SEARCH;
            end
            default: state_d = S_SEARCH;
        endcase

        pkt_hs = pkt_valid_i && pkt_ready_o;
        upd_hs = upd_valid_i && upd_ready_o;

        wait_cnt_d = wait_cnt_q;
        if (!upd_valid_i || upd_hs) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        // Output stage: each handshake becomes visible one cycle later.
        srch_valid_d = pkt_hs;
        srch_tuple_d = pkt_hs ? pkt_tuple_i : srch_tuple_q;
        tbl_we_d     = (upd_hs && grp_legal) ? (WE_W'(1) << upd_group_i) : '0;
        tbl_waddr_d  = upd_hs ? upd_index_i : tbl_waddr_q;
        tbl_wdata_d  = upd_hs ? upd_data_i : tbl_wdata_q;
        upd_err_d    = upd_hs && !grp_legal;
        drain_busy_d = state_d == S_DRAIN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_SEARCH;
            wait_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            burst_cnt_q  <= '0;
            srch_valid_q <= 1'b0;
            srch_tuple_q <= '0;
            tbl_we_q     <= '0;
            tbl_waddr_q  <= '0;
            tbl_wdata_q  <= '0;
            upd_err_q    <= 1'b0;
            drain_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            srch_valid_q <= srch_valid_d;
            srch_tuple_q <= srch_tuple_d;
            tbl_we_q     <= tbl_we_d;
            tbl_waddr_q  <= tbl_waddr_d;
            tbl_wdata_q  <= tbl_wdata_d;
            upd_err_q    <= upd_err_d;
            drain_busy_q <= drain_busy_d;
        end
    end

    assign srch_valid_o = srch_valid_q;
    assign srch_tuple_o = srch_tuple_q;
    assign tbl_we_o     = tbl_we_q;
    assign tbl_waddr_o  = tbl_waddr_q;
    assign tbl_wdata_o  = tbl_wdata_q;
    assign upd_err_o    = upd_err_q;
    assign drain_busy_o = drain_busy_q;

`ifdef SEARCH_SCHED_STATS_EN
    logic [31:0] stat_pkt_cnt_q, stat_upd_cnt_q, stat_drain_cyc_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_pkt_cnt_q   <= '0;
            stat_upd_cnt_q   <= '0;
            stat_drain_cyc_q <= '0;
        end else begin
            if (pkt_hs)             stat_pkt_cnt_q   <= stat_pkt_cnt_q + 32'd1;
            if (upd_hs)             stat_upd_cnt_q   <= stat_upd_cnt_q + 32'd1;
            if (state_q == S_DRAIN) stat_drain_cyc_q <= stat_drain_cyc_q + 32'd1;
        end
    end

    assign stat_pkt_cnt_o   = stat_pkt_cnt_q;
    assign stat_upd_cnt_o   = stat_upd_cnt_q;
    assign stat_drain_cyc_o = stat_drain_cyc_q;
`endif

endmodule

// File: tb/tb_search_update_scheduler.sv
// Scoreboard bench for search_update_scheduler: handshakes push expected outputs, a monitor pops and compares.
module tb_search_update_scheduler;

    localparam int unsigned DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid, pkt_ready;
    logic [103:0]      pkt_tuple;
    logic              upd_valid, upd_ready, upd_atomic;
    logic [2:0]        upd_group;
    logic [10:0]       upd_index;
    logic [DATA_W-1:0] upd_data;
    logic              srch_valid;
    logic [103:0]      srch_tuple;
    logic [5:0]        tbl_we;
    logic [10:0]       tbl_waddr;
    logic [DATA_W-1:0] tbl_wdata;
    logic              upd_err, drain_busy;

    typedef struct {
        logic [5:0]        we;
        logic [10:0]       addr;
        logic [DATA_W-1:0] data;
        logic              err;
    } wr_t;

    logic [103:0] srch_q[$];
    wr_t          upd_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int srch_seen = 0;
    logic pkt_hs_last = 1'b0;

    always #5 clk = ~clk;

    search_update_scheduler #(.PIPE_DEPTH(8), .STARVE_LIMIT(16), .BURST_MAX(4), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .pkt_valid_i(pkt_valid), .pkt_ready_o(pkt_ready), .pkt_tuple_i(pkt_tuple),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_group_i(upd_group),
        .upd_atomic_i(upd_atomic), .upd_index_i(upd_index), .upd_data_i(upd_data),
        .srch_valid_o(srch_valid), .srch_tuple_o(srch_tuple),
        .tbl_we_o(tbl_we), .tbl_waddr_o(tbl_waddr), .tbl_wdata_o(tbl_wdata),
        .upd_err_o(upd_err), .drain_busy_o(drain_busy)
    );

    // Monitor: compare this cycle's outputs, then record this cycle's handshakes.
    always @(negedge clk) begin
        pkt_hs_last = 1'b0;
        if (!rst) begin
            if (srch_valid) begin
                srch_seen++;
                n_checks++;
                if (srch_q.size() == 0) begin
                    n_fail++; $display("FAIL srch_unexpected: got tuple %0h, none expected", srch_tuple);
                end else begin
                    logic [103:0] exp_t;
                    exp_t = srch_q.pop_front();
                    if (srch_tuple !== exp_t) begin
                        n_fail++; $display("FAIL srch_tuple: got %0h expected %0h", srch_tuple, exp_t);
                    end
                end
                n_checks++;
                if (tbl_we !== 6'd0) begin
                    n_fail++; $display("FAIL overlap: tbl_we %b while srch_valid high", tbl_we);
                end
            end
            if (tbl_we !== 6'd0 || upd_err) begin
                n_checks++;
                if (upd_q.size() == 0) begin
                    n_fail++; $display("FAIL write_unexpected: got we %b err %b, none expected", tbl_we, upd_err);
                end else begin
                    wr_t e;
                    e = upd_q.pop_front();
                    if (tbl_we !== e.we || tbl_waddr !== e.addr || tbl_wdata !== e.data || upd_err !== e.err) begin
                        n_fail++;
                        $display("FAIL write: got we %b addr %0h data %0h err %b expected we %b addr %0h data %0h err %b",
                                 tbl_we, tbl_waddr, tbl_wdata, upd_err, e.we, e.addr, e.data, e.err);
                    end
                end
            end
            if (pkt_valid && pkt_ready) begin
                srch_q.push_back(pkt_tuple);
                pkt_hs_last = 1'b1;
            end
            if (upd_valid && upd_ready) begin
                wr_t w;
                logic [5:0] one;
                one    = 6'd1;
                w.we   = (upd_group <= 3'd5) ? (one << upd_group) : 6'd0;
                w.addr = upd_index;
                w.data = upd_data;
                w.err  = upd_group > 3'd5;
                upd_q.push_back(w);
            end
        end
    end

    // Move to just after the next rising edge, advancing the tuple if it was taken.
    task automatic adv();
        @(posedge clk);
        #1;
        if (pkt_hs_last) pkt_tuple = pkt_tuple + 104'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pkt_valid = 0; pkt_tuple = '0; upd_valid = 0; upd_atomic = 0;
        upd_group = '0; upd_index = '0; upd_data = '0;
        repeat (3) adv();
        @(negedge clk);
        n_checks++;
        if (srch_valid !== 1'b0 || tbl_we !== 6'd0 || upd_err !== 1'b0 || drain_busy !== 1'b0 ||
            srch_tuple !== '0 || tbl_waddr !== '0 || tbl_wdata !== '0) begin
            n_fail++; $display("FAIL reset_outputs: sv %b we %b err %b db %b", srch_valid, tbl_we, upd_err, drain_busy);
        end
        n_checks++;
        if (pkt_ready !== 1'b1 || upd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: pkt_ready %b upd_ready %b expected 1 0", pkt_ready, upd_ready);
        end
        adv();
        rst = 1'b0;
    endtask

    task automatic test_packets();
        int start_seen;
        start_seen = srch_seen;
        pkt_tuple = 104'h1; pkt_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (pkt_ready !== 1'b1) begin
                n_fail++; $display("FAIL pkt_ready_stream: cycle %0d got %b expected 1", i, pkt_ready);
            end
            adv();
        end
        pkt_valid = 1'b0;
        repeat (2) adv();
        n_checks++;
        if (srch_seen - start_seen !== 10) begin
            n_fail++; $display("FAIL pkt_count: got %0d srch_valid cycles expected 10", srch_seen - start_seen);
        end
    endtask

    task automatic test_nonatomic();
        upd_valid = 1; upd_atomic = 0; upd_group = 3'd2; upd_index = 11'h155; upd_data = 64'hDEAD;
        @(negedge clk);
        n_checks++;
        if (upd_ready !== 1'b1) begin
            n_fail++; $display("FAIL nonatomic_ready: got %b expected 1", upd_ready);
        end
        adv();
        upd_valid = 0;
        @(negedge clk);
        n_checks++;
        if (tbl_we !== 6'b000100 || tbl_waddr !== 11'h155 || tbl_wdata !== 64'hDEAD) begin
            n_fail++; $display("FAIL nonatomic_write: got we %b addr %0h data %0h expected 000100 155 dead",
                               tbl_we, tbl_waddr, tbl_wdata);
        end
        adv();
    endtask

    task automatic test_starvation();
        int c;
        c = -1;
        pkt_tuple = 104'h100; pkt_valid = 1;
        upd_valid = 1; upd_atomic = 0; upd_group = 3'd0; upd_index = 11'h7; upd_data = 64'h1234;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (upd_ready) begin c = i; break; end
            adv();
        end
        n_checks++;
        if (c !== 16) begin
            n_fail++; $display("FAIL starve_latency: got upd_ready at cycle %0d expected 16", c);
        end
        n_checks++;
        if (pkt_ready !== 1'b0) begin
            n_fail++; $display("FAIL starve_pkt_block: pkt_ready %b expected 0", pkt_ready);
        end
        adv();
        upd_valid = 0;
        @(negedge clk);
        n_checks++;
        if (tbl_we !== 6'b000001 || srch_valid !== 1'b0 || pkt_ready !== 1'b1) begin
            n_fail++; $display("FAIL starve_write: we %b sv %b pkt_ready %b expected 000001 0 1", tbl_we, srch_valid, pkt_ready);
        end
        adv();
        @(negedge clk);
        n_checks++;
        if (srch_valid !== 1'b1 || tbl_we !== 6'd0) begin
            n_fail++; $display("FAIL starve_resume: sv %b we %b expected 1 000000", srch_valid, tbl_we);
        end
        adv();
        pkt_valid = 0;
        repeat (2) adv();
    endtask

    task automatic test_atomic();
        int d;
        d = -1;
        pkt_tuple = 104'h200; pkt_valid = 1;
        upd_valid = 1; upd_atomic = 1; upd_group = 3'd4; upd_index = 11'h2AA; upd_data = 64'hCAFE_F00D;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!pkt_ready) begin d = i; break; end
            adv();
        end
        n_checks++;
        if (d !== 16 || srch_valid !== 1'b1 || upd_ready !== 1'b0) begin
            n_fail++; $display("FAIL atomic_decide: cycle %0d sv %b upd_ready %b expected 16 1 0", d, srch_valid, upd_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            adv();
            @(negedge clk);
            n_checks++;
            if (drain_busy !== 1'b1 || srch_valid !== 1'b0 || upd_ready !== 1'b0 || pkt_ready !== 1'b0) begin
                n_fail++; $display("FAIL atomic_drain: drain cycle %0d db %b sv %b upd_ready %b pkt_ready %b expected 1 0 0 0",
                                   k, drain_busy, srch_valid, upd_ready, pkt_ready);
            end
        end
        adv();
        @(negedge clk);
        n_checks++;
        if (upd_ready !== 1'b1 || drain_busy !== 1'b0 || srch_valid !== 1'b0 || pkt_ready !== 1'b0) begin
            n_fail++; $display("FAIL atomic_ready: upd_ready %b db %b sv %b pkt_ready %b expected 1 0 0 0",
                               upd_ready, drain_busy, srch_valid, pkt_ready);
        end
        adv();
        upd_valid = 0;
        @(negedge clk);
        n_checks++;
        if (tbl_we !== 6'b010000 || srch_valid !== 1'b0) begin
            n_fail++; $display("FAIL atomic_write: we %b sv %b expected 010000 0", tbl_we, srch_valid);
        end
        adv();
        pkt_valid = 0;
        repeat (2) adv();
    endtask

    task automatic test_illegal();
        upd_valid = 1; upd_atomic = 0; upd_group = 3'd7; upd_index = 11'h0AB; upd_data = 64'hBAD;
        @(negedge clk);
        n_checks++;
        if (upd_ready !== 1'b1) begin
            n_fail++; $display("FAIL illegal_ready: got %b expected 1", upd_ready);
        end
        adv();
        upd_valid = 0;
        @(negedge clk);
        n_checks++;
        if (tbl_we !== 6'd0 || upd_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_err: we %b err %b expected 000000 1", tbl_we, upd_err);
        end
        adv();
        @(negedge clk);
        n_checks++;
        if (upd_err !== 1'b0) begin
            n_fail++; $display("FAIL illegal_pulse: err %b expected 0", upd_err);
        end
        adv();
    endtask

    task automatic test_reset_mid_drain();
        int c, w;
        c = -1; w = -1;
        pkt_valid = 0;
        upd_valid = 1; upd_atomic = 1; upd_group = 3'd1; upd_index = 11'h3C3; upd_data = 64'h5A5A;
        @(negedge clk);
        n_checks++;
        if (pkt_ready !== 1'b0 || upd_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_decide: pkt_ready %b upd_ready %b expected 0 0", pkt_ready, upd_ready);
        end
        adv(); adv(); adv();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (drain_busy !== 1'b1) begin
            n_fail++; $display("FAIL rd_drain3: drain_busy %b expected 1", drain_busy);
        end
        adv();
        rst = 1'b0; pkt_valid = 1; pkt_tuple = 104'h300;
        @(negedge clk);
        n_checks++;
        if (drain_busy !== 1'b0 || srch_valid !== 1'b0 || tbl_we !== 6'd0 || upd_err !== 1'b0 ||
            pkt_ready !== 1'b1 || upd_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_after_reset: db %b sv %b we %b err %b pkt_ready %b upd_ready %b expected 0 0 0 0 1 0",
                               drain_busy, srch_valid, tbl_we, upd_err, pkt_ready, upd_ready);
        end
        for (int i = 1; i < 40; i++) begin
            adv();
            @(negedge clk);
            if (!pkt_ready) begin c = i; break; end
        end
        n_checks++;
        if (c !== 16) begin
            n_fail++; $display("FAIL rd_rearb: re-arbitration at cycle %0d expected 16", c);
        end
        for (int i = 1; i < 20; i++) begin
            adv();
            @(negedge clk);
            if (upd_ready) begin w = i; break; end
        end
        n_checks++;
        if (w !== 9) begin
            n_fail++; $display("FAIL rd_write_ready: upd_ready %0d cycles after decision expected 9", w);
        end
        adv();
        upd_valid = 0; pkt_valid = 0;
        repeat (3) adv();
    endtask

    initial begin
        test_reset();
        test_packets();
        test_nonatomic();
        test_starvation();
        test_atomic();
        test_illegal();
        test_reset_mid_drain();
        @(negedge clk);
        n_checks++;
        if (srch_q.size() != 0 || upd_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d searches and %0d writes never appeared", srch_q.size(), upd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/search_update_scheduler.md
Name: search_update_scheduler

Overview:
- Front-end controller for one search_stage pipeline; shares the pipeline's slot each clock between packet searches and rule-table update writes.
- Enforces update starvation limits and search bursting limits.
- Atomic updates drain in-flight searches before the write, so no packet sees a partially updated rule chain.
- Sits between the packet/tuple source and the update engine on one side, and the search_stage chain plus its G0–G4other table write ports on the other.

Parameters:
- PIPE_DEPTH, 8: number of search stages in flight; atomic drain length in cycles (1..255).
- STARVE_LIMIT, 16: cycles an update may wait before it preempts searches (1..255).
- BURST_MAX, 4: maximum consecutive non-atomic writes while a packet is waiting (1..15).
- DATA_W, 64: table entry write-data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- pkt_valid  in  1  tuple available.
- pkt_ready  out  1  tuple accepted this cycle (combinational from state/counters).
- pkt_tuple  in  104  5-tuple search key.
- upd_valid  in  1  update request pending; must hold stable until upd_ready.
- upd_ready  out  1  update accepted this cycle (combinational).
- upd_group  in  3  target table: 0..4 = G0..G4, 5 = G4other, 6/7 illegal.
- upd_atomic  in  1  drain pipeline before write.
- upd_index  in  11  table entry index.
- upd_data  in  DATA_W  entry contents.
- srch_valid  out  1  registered; tuple issued to search_stage.
- srch_tuple  out  104  registered tuple.
- tbl_we  out  6  registered one-hot write enable, bit n = group n.
- tbl_waddr  out  11  registered write index.
- tbl_wdata  out  DATA_W  registered write data.
- upd_err  out  1  registered one-cycle pulse: illegal group accepted and dropped.
- drain_busy  out  1  registered; high while in S_DRAIN.

Behaviour:
- Reset values:
  - All registered outputs are 0.
  - State is S_SEARCH.
  - wait_cnt, burst_cnt and drain_cnt are 0.
  - A pending drain or write is discarded; the update is re-presented by the requester.
- Latency: every handshake at edge N produces its output at edge N+1. At most one of srch_valid or |tbl_we is high in any cycle.
- wait_cnt:
  - Increments, saturating at 255, each cycle upd_valid && !upd_ready.
  - Clears on an upd handshake or when upd_valid is low.
- take_upd: upd_valid && (!pkt_valid || wait_cnt >= STARVE_LIMIT) && !(pkt_valid && burst_cnt == BURST_MAX).
  - The starve condition overrides the burst limit.
- S_SEARCH:
  - If take_upd && !upd_atomic: upd_ready = 1, pkt_ready = 0. Next cycle tbl_we[upd_group] = 1 with waddr/wdata. burst_cnt++ only when pkt_valid was high. Stay in S_SEARCH.
  - If take_upd && upd_atomic: pkt_ready = 0, upd_ready = 0. drain_cnt <= PIPE_DEPTH; go to S_DRAIN.
  - Otherwise: pkt_ready = 1. A packet handshake gives srch_valid = 1 and srch_tuple next cycle. burst_cnt clears on any packet handshake.
- S_DRAIN:
  - pkt_ready = 0, upd_ready = 0, drain_busy = 1.
  - drain_cnt decrements each cycle; at 1, go to S_WRITE.
  - Result: exactly PIPE_DEPTH cycles with srch_valid = 0 after the last search.
  - If upd_valid drops (protocol violation), return to S_SEARCH with no write.
- S_WRITE:
  - upd_ready = 1 for exactly one cycle; write issued next cycle as above.
  - pkt_ready = 0; return to S_SEARCH.
- Illegal group (6/7): accepted normally, with drain if atomic. tbl_we stays 0; upd_err pulses in the cycle the write would have appeared.
- Simultaneous pkt_valid and upd_valid with wait_cnt < STARVE_LIMIT: the packet wins.

Optional Feature:
- Macro: SEARCH_SCHED_STATS_EN.
- When defined, adds three 32-bit output ports, all cleared by rst and wrapping at 2^32:
  - stat_pkt_cnt: packet handshakes.
  - stat_upd_cnt: upd handshakes.
  - stat_drain_cyc: cycles spent in S_DRAIN.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Packets only: 10 back-to-back tuples 0x1..0xA with upd_valid = 0 → srch_valid high for 10 cycles, each tuple one cycle after its handshake, in order; tbl_we = 0 throughout.
- Non-atomic update, pkt_valid = 0: upd_group = 2, upd_index = 0x155, upd_data = 0xDEAD → upd_ready same cycle; next cycle tbl_we = 6'b000100, tbl_waddr = 0x155, tbl_wdata = 0xDEAD.
- Starvation: pkt_valid held high, upd_valid asserted non-atomic → upd_ready after exactly 16 cycles (STARVE_LIMIT); tbl_we pulses once, then packets resume.
- Atomic update mid-stream, with forced starvation: the last srch_valid is followed by 8 idle cycles with drain_busy = 1; upd_ready on cycle 9; tbl_we on cycle 10; no srch_valid overlaps.
- Illegal group: upd_group = 7, non-atomic → upd_ready = 1, tbl_we stays 0, upd_err = 1 for one cycle.
- Reset mid-drain: assert rst on drain cycle 3 → next cycle all outputs 0, drain_busy = 0, state S_SEARCH; held update re-arbitrates with wait_cnt = 0.
